// File: rtl/lc3_mem_arbiter.sv
// lc3_mem_arbiter: shares one single-port memory between LC3 fetch and
// mem-access stages. Data has priority, fetch starvation is bounded by a
// streak counter, and a watchdog aborts accesses the memory never acks.
module lc3_mem_arbiter #(
  parameter int unsigned ADDR_W       = 16,
  parameter int unsigned DATA_W       = 16,
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned TIMEOUT      = 255
) (
  input  logic              clock,
  input  logic              reset,
  // fetch port
  input  logic              instrmem_rd,
  input  logic [ADDR_W-1:0] pc,
  output logic [DATA_W-1:0] Instr_dout,
  output logic              complete_instr,
  // data port
  input  logic              data_req,
  input  logic              Data_rd,
  input  logic [ADDR_W-1:0] Data_addr,
  input  logic [DATA_W-1:0] Data_din,
  output logic [DATA_W-1:0] Data_dout,
  output logic              complete_data,
  // memory port
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  // status
  output logic              timeout_err
);

  localparam int unsigned STREAK_W = $clog2(STARVE_LIMIT + 1);
  localparam int unsigned WAIT_W   = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    INSTR = 2'd1,
    DATA  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t              state;
  logic [STREAK_W-1:0] streak;
  logic [WAIT_W-1:0]   wait_cnt;

  logic streak_ok;
  logic pick_data;
  logic wait_hit;

  // Arbitration and watchdog decisions, evaluated from registered state.
  assign streak_ok = (streak < STREAK_W'(STARVE_LIMIT));
  assign pick_data = data_req && (!instrmem_rd || streak_ok);
  assign wait_hit  = (TIMEOUT != 0) && (wait_cnt == WAIT_W'(TIMEOUT));

  // Arbiter FSM with registered memory-side and core-side outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      streak         <= '0;
      wait_cnt       <= '0;
      mem_req        <= 1'b0;
      mem_we         <= 1'b0;
      mem_addr       <= '0;
      mem_wdata      <= '0;
      Instr_dout     <= '0;
      Data_dout      <= '0;
      complete_instr <= 1'b0;
      complete_data  <= 1'b0;
      timeout_err    <= 1'b0;
    end else begin
      complete_instr <= 1'b0;
      complete_data  <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_data) begin
            state     <= DATA;
            mem_req   <= 1'b1;
            mem_we    <= !Data_rd;
            mem_addr  <= Data_addr;
            mem_wdata <= Data_din;
            wait_cnt  <= '0;
            if (!instrmem_rd) begin
              streak <= '0;
            end else if (streak_ok) begin
              streak <= streak + STREAK_W'(1);
            end
          end else if (instrmem_rd) begin
            state    <= INSTR;
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= pc;
            wait_cnt <= '0;
            streak   <= '0;
          end
        end
        INSTR, DATA: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            state   <= RESP;
            if (state == INSTR) begin
              Instr_dout     <= mem_rdata;
              complete_instr <= 1'b1;
            end else begin
              if (!mem_we) begin
                Data_dout <= mem_rdata;
              end
              complete_data <= 1'b1;
            end
          end else if (wait_hit) begin
            mem_req     <= 1'b0;
            timeout_err <= 1'b1;
            state       <= RESP;
            if (state == INSTR) begin
              Instr_dout     <= '0;
              complete_instr <= 1'b1;
            end else begin
              Data_dout     <= '0;
              complete_data <= 1'b1;
            end
          end else if (wait_cnt != '1) begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lc3_mem_arbiter.sv
// Scoreboard bench for lc3_mem_arbiter: stimulus pushes expected grants and
// completions, a monitor pops and compares when the DUT presents them.
module tb_lc3_mem_arbiter;

  localparam int unsigned SL = 4;
  localparam int unsigned TO = 8;

  typedef struct packed {
    logic [15:0] addr;
    logic        we;
    logic [15:0] wdata;
    logic        chk_wdata;
    logic [7:0]  cycles;   // expected mem_req high cycles, 0 = not checked
  } grant_t;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        instrmem_rd = 1'b0;
  logic [15:0] pc = '0;
  logic [15:0] Instr_dout;
  logic        complete_instr;
  logic        data_req = 1'b0;
  logic        Data_rd = 1'b0;
  logic [15:0] Data_addr = '0;
  logic [15:0] Data_din = '0;
  logic [15:0] Data_dout;
  logic        complete_data;
  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata = '0;
  logic        mem_ack = 1'b0;
  logic        timeout_err;

  int compared = 0;
  int mismatched = 0;
  int n_ci = 0;
  int n_cd = 0;

  grant_t      exp_grant[$];
  logic [15:0] exp_instr[$];
  logic [15:0] exp_data[$];

  int mem_wait = 0;
  bit no_ack = 1'b0;
  int mcnt = 0;

  always #5 clock = ~clock;

  lc3_mem_arbiter #(
    .ADDR_W(16), .DATA_W(16), .STARVE_LIMIT(SL), .TIMEOUT(TO)
  ) dut (
    .clock(clock), .reset(reset),
    .instrmem_rd(instrmem_rd), .pc(pc),
    .Instr_dout(Instr_dout), .complete_instr(complete_instr),
    .data_req(data_req), .Data_rd(Data_rd), .Data_addr(Data_addr),
    .Data_din(Data_din), .Data_dout(Data_dout), .complete_data(complete_data),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .timeout_err(timeout_err)
  );

  function automatic logic [15:0] rdata_of(input logic [15:0] a);
    if (a == 16'h3000) return 16'h1261;
    return a ^ 16'hA5A5;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail(input string name, input string msg);
    compared++;
    mismatched++;
    $display("FAIL %s: %s (t=%0t)", name, msg, $time);
  endtask

  // Memory model: acks after mem_wait wait cycles unless no_ack is set.
  always @(negedge clock) begin
    if (mem_req && !no_ack) begin
      if (mcnt >= mem_wait) begin
        mem_ack   = 1'b1;
        mem_rdata = rdata_of(mem_addr);
        mcnt      = 0;
      end else begin
        mem_ack = 1'b0;
        mcnt++;
      end
    end else begin
      mem_ack = 1'b0;
      mcnt    = 0;
    end
  end

  // Monitor: compares grants, request hold time and completions.
  logic   prev_req = 1'b0;
  logic   prev_ci = 1'b0;
  logic   prev_cd = 1'b0;
  grant_t cur = '0;
  int     cyc = 0;
  always @(negedge clock) begin
    if (mem_req === 1'b1) begin
      if (!prev_req) begin
        if (exp_grant.size() == 0) begin
          fail("unexpected_grant", $sformatf("addr %h we %b", mem_addr, mem_we));
          cur = '0;
        end else begin
          cur = exp_grant.pop_front();
          check("grant_addr", 32'(mem_addr), 32'(cur.addr));
          check("grant_we", 32'(mem_we), 32'(cur.we));
          if (cur.chk_wdata) check("grant_wdata", 32'(mem_wdata), 32'(cur.wdata));
        end
        cyc = 1;
      end else begin
        check("hold_addr", 32'(mem_addr), 32'(cur.addr));
        check("hold_we", 32'(mem_we), 32'(cur.we));
        if (cur.chk_wdata) check("hold_wdata", 32'(mem_wdata), 32'(cur.wdata));
        cyc++;
      end
    end else if (prev_req && cur.cycles != 0) begin
      check("req_cycles", 32'(cyc), 32'(cur.cycles));
    end
    if (complete_instr === 1'b1) begin
      check("ci_one_cycle", 32'(prev_ci), 32'd0);
      if (exp_instr.size() == 0) fail("unexpected_complete_instr", "queue empty");
      else check("Instr_dout", 32'(Instr_dout), 32'(exp_instr.pop_front()));
      n_ci++;
    end
    if (complete_data === 1'b1) begin
      check("cd_one_cycle", 32'(prev_cd), 32'd0);
      if (exp_data.size() == 0) fail("unexpected_complete_data", "queue empty");
      else check("Data_dout", 32'(Data_dout), 32'(exp_data.pop_front()));
      n_cd++;
    end
    prev_req = (mem_req === 1'b1);
    prev_ci  = (complete_instr === 1'b1);
    prev_cd  = (complete_data === 1'b1);
  end

  task automatic wait_done(input int ci_t, input int cd_t, input int budget, input string name);
    for (int i = 0; i < budget; i++) begin
      if (n_ci >= ci_t && n_cd >= cd_t) return;
      @(negedge clock);
      #1;
    end
    fail(name, "completion wait expired");
  endtask

  task automatic push_grant(input logic [15:0] a, input logic we, input logic [15:0] wd,
                            input logic chk, input logic [7:0] cyc_n);
    grant_t g;
    g.addr = a; g.we = we; g.wdata = wd; g.chk_wdata = chk; g.cycles = cyc_n;
    exp_grant.push_back(g);
  endtask

  initial begin
    #200000;
    $display("FAIL global_watchdog: simulation time limit reached");
    $fatal(1, "global watchdog");
  end

  initial begin
    // Reset and idle
    reset = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    #1;
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_mem_wdata", 32'(mem_wdata), 32'd0);
    check("rst_Instr_dout", 32'(Instr_dout), 32'd0);
    check("rst_Data_dout", 32'(Data_dout), 32'd0);
    check("rst_complete", 32'({complete_instr, complete_data}), 32'd0);
    check("rst_timeout_err", 32'(timeout_err), 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clock); #1;
      check("idle_mem_req", 32'(mem_req), 32'd0);
    end

    // Single zero-wait fetch
    mem_wait = 0;
    push_grant(16'h3000, 1'b0, 16'h0, 1'b0, 8'd1);
    exp_instr.push_back(16'h1261);
    instrmem_rd = 1'b1; pc = 16'h3000;
    wait_done(n_ci + 1, n_cd, 20, "fetch_done");
    instrmem_rd = 1'b0;

    // Data write with 3 wait states; Data_dout keeps its reset value
    mem_wait = 3;
    push_grant(16'h3100, 1'b1, 16'hBEEF, 1'b1, 8'd4);
    exp_data.push_back(16'h0000);
    data_req = 1'b1; Data_rd = 1'b0; Data_addr = 16'h3100; Data_din = 16'hBEEF;
    wait_done(n_ci, n_cd + 1, 30, "write_done");
    data_req = 1'b0;

    // Both requests held: D,D,D,D,I,D,D,D,D,I
    mem_wait = 0;
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < 4; k++) begin
        push_grant(16'h4000, 1'b0, 16'h1234, 1'b1, 8'd1);
        exp_data.push_back(16'hE5A5);
      end
      push_grant(16'h5000, 1'b0, 16'h0, 1'b0, 8'd1);
      exp_instr.push_back(16'hF5A5);
    end
    repeat (2) @(negedge clock);
    data_req = 1'b1; Data_rd = 1'b1; Data_addr = 16'h4000; Data_din = 16'h1234;
    instrmem_rd = 1'b1; pc = 16'h5000;
    wait_done(n_ci + 2, n_cd + 8, 100, "starve_done");
    data_req = 1'b0; instrmem_rd = 1'b0;

    // Timeout on a data read, then a normal fetch
    repeat (2) @(negedge clock);
    no_ack = 1'b1;
    push_grant(16'h3200, 1'b0, 16'h0, 1'b0, 8'(TO + 1));
    exp_data.push_back(16'h0000);
    data_req = 1'b1; Data_rd = 1'b1; Data_addr = 16'h3200;
    wait_done(n_ci, n_cd + 1, 50, "timeout_done");
    data_req = 1'b0;
    no_ack = 1'b0;
    #1;
    check("timeout_err_set", 32'(timeout_err), 32'd1);
    push_grant(16'h3002, 1'b0, 16'h0, 1'b0, 8'd1);
    exp_instr.push_back(16'h95A7);
    instrmem_rd = 1'b1; pc = 16'h3002;
    wait_done(n_ci + 1, n_cd, 20, "post_timeout_fetch");
    instrmem_rd = 1'b0;
    check("timeout_err_sticky", 32'(timeout_err), 32'd1);

    // Async reset during a data wait
    repeat (2) @(negedge clock);
    no_ack = 1'b1;
    push_grant(16'h3300, 1'b0, 16'h0, 1'b0, 8'd0);
    data_req = 1'b1; Data_rd = 1'b1; Data_addr = 16'h3300;
    begin
      int k;
      k = 0;
      while (mem_req !== 1'b1 && k < 10) begin @(posedge clock); #1; k++; end
      if (mem_req !== 1'b1) fail("async_rst_grant", "mem_req never rose");
    end
    repeat (3) @(posedge clock);
    #2;
    reset = 1'b0;
    #1;
    check("async_rst_mem_req", 32'(mem_req), 32'd0);
    check("async_rst_timeout_err", 32'(timeout_err), 32'd0);
    check("async_rst_complete", 32'(complete_data), 32'd0);
    @(negedge clock);
    data_req = 1'b0;
    no_ack = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b1;
    repeat (10) @(negedge clock);
    #1;
    check("post_rst_mem_req", 32'(mem_req), 32'd0);
    check("post_rst_Data_dout", 32'(Data_dout), 32'd0);

    check("grant_q_empty", 32'(exp_grant.size()), 32'd0);
    check("instr_q_empty", 32'(exp_instr.size()), 32'd0);
    check("data_q_empty", 32'(exp_data.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/lc3_mem_arbiter.md
# lc3_mem_arbiter

Single-port memory arbiter for the LC3 pipeline. It shares one unified instruction/data memory between the Fetch stage (`instrmem_rd`/`pc`) and the MemAccess stage (`Data_addr`/`Data_rd`/`Data_din`). It returns `Instr_dout`/`complete_instr` and `Data_dout`/`complete_data` to the core. Data accesses have priority, instruction fetch has bounded starvation, and a bus-timeout watchdog guards against a hung memory.

## Interface
- `ADDR_W`, 16, address width
- `DATA_W`, 16, data width
- `STARVE_LIMIT`, 4, max consecutive data grants while a fetch is pending (≥1)
- `TIMEOUT`, 255, cycles to wait for `mem_ack` before aborting; 0 disables
---
- `clock` in 1: sole clock, rising edge
- `reset` in 1: asynchronous, active-low
- `instrmem_rd` in 1: fetch request level, held until `complete_instr`
- `pc` in ADDR_W: fetch address
- `Instr_dout` out DATA_W: fetched instruction, registered
- `complete_instr` out 1: one-cycle fetch completion pulse
- `data_req` in 1: data request level, held until `complete_data`
- `Data_rd` in 1: 1 = read, 0 = write
- `Data_addr` in ADDR_W: data address
- `Data_din` in DATA_W: write data
- `Data_dout` out DATA_W: read data, registered
- `complete_data` out 1: one-cycle data completion pulse
- `mem_req` out 1: memory request, held until ack
- `mem_we` out 1: write strobe qualifier
- `mem_addr` out ADDR_W: memory address
- `mem_wdata` out DATA_W: memory write data
- `mem_rdata` in DATA_W: memory read data, valid with `mem_ack`
- `mem_ack` in 1: memory completion, sampled on `clock`
- `timeout_err` out 1: sticky watchdog flag

## Operation
- FSM states: IDLE, INSTR, DATA, RESP.
- IDLE, arbitration at the clock edge:
  - If `data_req` is set, and either `instrmem_rd` is clear or `streak < STARVE_LIMIT`, go to DATA.
  - Otherwise, if `instrmem_rd` is set, go to INSTR.
  - Otherwise, stay in IDLE.
- On a grant, latch the address, `mem_we` (= `!Data_rd` for data, 0 for fetch) and `mem_wdata` into registers. Set `mem_req` = 1.
- Streak counter update:
  - Data grant with `instrmem_rd` high: increment, saturating at `STARVE_LIMIT`.
  - Data grant with `instrmem_rd` low: clear to 0.
  - Fetch grant: clear to 0.
- INSTR/DATA: hold `mem_req` and the latched outputs stable. Requester inputs are ignored until the state returns to IDLE.
- `mem_ack` high in INSTR/DATA:
  - Clear `mem_req`.
  - Capture `mem_rdata` into `Instr_dout` (INSTR) or `Data_dout` (DATA read only). Data writes leave `Data_dout` unchanged.
  - Go to RESP.
- RESP: pulse the matching `complete_*` for exactly one cycle, then return to IDLE. No arbitration occurs in RESP. The requester drops or changes its request during this cycle.
- Watchdog: a wait counter clears on every grant and increments each cycle in INSTR/DATA without ack. When it reaches `TIMEOUT` (if nonzero):
  - Clear `mem_req` and set `timeout_err`.
  - Load the target `*_dout` with 0.
  - Go to RESP, so the completion still pulses.
- `timeout_err` clears only on reset.
- `mem_ack` in IDLE/RESP is ignored.
- A request withdrawn mid-transaction does not abort the transaction; its completion pulse is still issued.

## Timing
- Reset (`reset` = 0), asynchronous: state IDLE; streak and wait counters 0; all outputs 0 (`mem_req`, `mem_we`, `mem_addr`, `mem_wdata`, `Instr_dout`, `Data_dout`, `complete_*`, `timeout_err`).
- Reset mid-transaction drops `mem_req` immediately. The pending access is lost and no completion is issued.
- Minimum latency: request high in cycle 0, grant at the end of cycle 0. `mem_req` is high in cycle 1, with ack at earliest in cycle 1. `complete_*` and `*_dout` are valid in cycle 2. IDLE is reached in cycle 3.
- Peak throughput: one access per 3 cycles with zero-wait memory. Each memory wait state adds one cycle.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Both requests arriving in the same cycle resolve per the IDLE rule. The streak state at that edge decides the winner.
- Timeout fires in the cycle after `TIMEOUT` wait cycles. With ack in that same cycle, the ack wins.
- Widths: the counters saturate and never wrap. The wait counter is `$clog2(TIMEOUT+1)` bits.

## Test plan
- Reset/idle: hold `reset` low 3 cycles, then release with no requests → all outputs 0, `mem_req` stays 0.
- Single fetch, zero-wait: `instrmem_rd` = 1, `pc` = 16'h3000, `mem_ack` in the first `mem_req` cycle, `mem_rdata` = 16'h1261 → `mem_addr` = 16'h3000, `mem_we` = 0. `complete_instr` pulses in cycle 2 with `Instr_dout` = 16'h1261.
- Data write with 3 wait states: `data_req` = 1, `Data_rd` = 0, `Data_addr` = 16'h3100, `Data_din` = 16'hBEEF → `mem_we` = 1, `mem_wdata` = 16'hBEEF held 4 cycles. `complete_data` pulses once; `Data_dout` unchanged.
- Priority/starvation: `data_req` and `instrmem_rd` held continuously, `STARVE_LIMIT` = 4 → grant order D,D,D,D,I,D,D,D,D,I.
- Timeout: `TIMEOUT` = 8, never ack a data read → `mem_req` drops after 8 wait cycles. `timeout_err` = 1 sticky, `complete_data` pulses, `Data_dout` = 0. The next fetch still completes normally.
- Async reset mid-access: assert `reset` low during DATA wait, away from a clock edge → `mem_req` = 0 at once. No `complete_data` after release, and `timeout_err` is cleared.
